// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_stage : ID/EX pipeline register with load-use hazard detection.    |
// | Optional macro LOAD_USE_DETECT_EN enables automatic load-use bubbles.    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module id_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      rs1D,
   input  logic [4:0]      rs2D,
   input  logic [4:0]      rdD,
   input  logic [XLEN-1:0] rd1D,
   input  logic [XLEN-1:0] rd2D,
   input  logic [XLEN-1:0] immD,
   input  logic [XLEN-1:0] pcD,
   input  logic [XLEN-1:0] pc4D,
   input  logic            validD,
   input  logic            RegWriteD,
   input  logic            MemWriteD,
   input  logic            ALUSrcD,
   input  logic            BranchD,
   input  logic            JumpD,
   input  logic [1:0]      ResultSrcD,
   input  logic [3:0]      ALUControlD,
   input  logic            flushE,
   input  logic            stallE,
   output logic [4:0]      rs1E,
   output logic [4:0]      rs2E,
   output logic [4:0]      rdE,
   output logic [XLEN-1:0] rd1E,
   output logic [XLEN-1:0] rd2E,
   output logic [XLEN-1:0] immE,
   output logic [XLEN-1:0] pcE,
   output logic [XLEN-1:0] pc4E,
   output logic            validE,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            ALUSrcE,
   output logic            BranchE,
   output logic            JumpE,
   output logic [1:0]      ResultSrcE,
   output logic [3:0]      ALUControlE,
   output logic            stallF,
   output logic            stallD
);

   localparam logic [1:0] RESULT_LOAD = 2'b01;

   typedef struct packed {
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic            valid;
      logic            reg_write;
      logic            mem_write;
      logic            alu_src;
      logic            branch;
      logic            jump;
      logic [1:0]      result_src;
      logic [3:0]      alu_control;
   } ex_t;

   ex_t  ex_q;
   ex_t  ex_d;
   ex_t  dec;
   logic lu_hazard;

   // Side-effecting controls are squashed for an empty Decode slot.
   always_comb begin
      dec.rs1         = rs1D;
      dec.rs2         = rs2D;
      dec.rd          = rdD;
      dec.rd1         = rd1D;
      dec.rd2         = rd2D;
      dec.imm         = immD;
      dec.pc          = pcD;
      dec.pc4         = pc4D;
      dec.valid       = validD;
      dec.reg_write   = RegWriteD & validD;
      dec.mem_write   = MemWriteD & validD;
      dec.alu_src     = ALUSrcD;
      dec.branch      = BranchD & validD;
      dec.jump        = JumpD & validD;
      dec.result_src  = ResultSrcD;
      dec.alu_control = ALUControlD;
   end

`ifdef LOAD_USE_DETECT_EN
   assign lu_hazard = ex_q.valid && (ex_q.result_src == RESULT_LOAD) && (ex_q.rd != 5'd0)
                      && validD && ((ex_q.rd == rs1D) || (ex_q.rd == rs2D));
`else
   assign lu_hazard = 1'b0;
`endif

   assign stallF = (stallE | lu_hazard) & ~flushE;
   assign stallD = stallF;

   always_comb begin
      ex_d = ex_q;
      if (flushE) begin
         ex_d = '0;
      end else if (stallE) begin
         ex_d = ex_q;
      end else if (lu_hazard) begin
         ex_d = '0;
      end else begin
         ex_d = dec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign rs1E        = ex_q.rs1;
   assign rs2E        = ex_q.rs2;
   assign rdE         = ex_q.rd;
   assign rd1E        = ex_q.rd1;
   assign rd2E        = ex_q.rd2;
   assign immE        = ex_q.imm;
   assign pcE         = ex_q.pc;
   assign pc4E        = ex_q.pc4;
   assign validE      = ex_q.valid;
   assign RegWriteE   = ex_q.reg_write;
   assign MemWriteE   = ex_q.mem_write;
   assign ALUSrcE     = ex_q.alu_src;
   assign BranchE     = ex_q.branch;
   assign JumpE       = ex_q.jump;
   assign ResultSrcE  = ex_q.result_src;
   assign ALUControlE = ex_q.alu_control;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 5-stage RISC-V core: captures decoded operands, register addresses and control from Decode and presents them to Execute. It provides the `rs1E`/`rs2E`/`rdE` addresses consumed by the forwarding unit, and the `RegWriteE` bit that the forwarding unit later sees as `RegWriteM`. It also detects load-use hazards, producing Fetch/Decode stall requests and inserting a bubble into Execute. It handles branch flush and downstream hold.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `rs1D`, `rs2D`, `rdD`  in  5 each  Decode register addresses
- `rd1D`, `rd2D`  in  XLEN each  register-file read data
- `immD`, `pcD`, `pc4D`  in  XLEN each  immediate, PC, PC+4
- `validD`  in  1  Decode slot holds a real instruction
- `RegWriteD`, `MemWriteD`, `ALUSrcD`, `BranchD`, `JumpD`  in  1 each  control
- `ResultSrcD`  in  2  result select; `2'b01` = load
- `ALUControlD`  in  4  ALU op
- `flushE`  in  1  branch/jump taken; kill instruction entering E
- `stallE`  in  1  downstream hold; E contents frozen
- `rs1E`, `rs2E`, `rdE`, `rd1E`, `rd2E`, `immE`, `pcE`, `pc4E`, `validE`, and all `*E` control  out  widths as the D inputs  registered Execute copies
- `stallF`, `stallD`  out  1 each  hold PC and IF/ID register

## Operation
- Load-use hazard `lu`:
  - Asserted when `validE & (ResultSrcE==2'b01) & (rdE!=0) & validD & ((rdE==rs1D)|(rdE==rs2D))`.
  - Combinational from registered E state and D inputs.
- Stall outputs:
  - `stallF = stallD = (stallE | lu) & !flushE`.
- Next-state priority, evaluated each rising edge:
  1. `rst`: all E outputs 0, asynchronously.
  2. `flushE`: bubble.
  3. `stallE`: hold all E registers.
  4. `lu`: bubble.
  5. Otherwise: load all D inputs.
- Bubble definition:
  - All E registers written 0, including `validE`, `RegWriteE`, `MemWriteE`, `BranchE`, `JumpE`, `rdE`.
  - A bubble therefore can never forward, write or branch.
- `rdE` is passed unchanged when `RegWriteD=0`.
  - The forwarding unit gates on `RegWrite`; this stage does not zero `rdE`.
- `validD=0` loads normally, but `RegWriteE`, `MemWriteE`, `BranchE` and `JumpE` are forced 0.
- No arithmetic is performed; all fields are a pure width-preserving transfer.

## Timing
- Latency: 1 cycle from D inputs to E outputs.
- Reset:
  - Every registered output is 0.
  - `stallF`/`stallD` are 0 unless `stallE` is high, because `validE=0` during reset.
- `lu` stall lasts exactly 1 cycle. Next cycle:
  - The bubble is in E, so `validE=0` and `lu` deasserts.
  - The load has moved to M, where forwarding covers it.
- Simultaneous events:
  - `flushE` with `lu`: bubble, stalls 0.
  - `flushE` with `stallE`: flush wins and E is cleared.
  - `stallE` with `lu`: hold, with stalls asserted. `lu` re-evaluates from the unchanged E after `stallE` drops.
- Reset mid-stall: stalls and bubble state clear immediately; there is no pending state after reset.

## Configuration
- Macro: `LOAD_USE_DETECT_EN`.
- Defined: `lu` logic as specified above.
- Undefined:
  - `lu` is tied 0.
  - `stallF = stallD = stallE & !flushE`.
  - No automatic bubble is inserted; load-use spacing is the compiler's responsibility.
  - All other behaviour is unchanged.

## Test plan
- Reset: hold `rst` with nonzero D inputs -> all E outputs 0 and `stallF=0`; first edge after release loads D, e.g. `rdE=5`, `rd1E=32'hDEADBEEF`.
- Load-use: E holds a load with `rdE=3` and `validE=1`; D has `rs2D=3` -> `stallF=stallD=1` that cycle; next edge `validE=0`, `RegWriteE=0`; following edge loads the stalled instruction; stall asserted exactly 1 cycle.
- x0 and non-load cases:
  - Load with `rdE=0`, `rs1D=0` -> no stall.
  - ALU op (`ResultSrcE=2'b00`) with `rdE=rs1D=7` -> no stall.
- Flush priority: `flushE=1` with `lu` true -> `stallF=0`; E bubbled next edge with `BranchE=0` and `JumpE=0`.
- Hold: `stallE=1` for 3 cycles with changing D -> E outputs constant and `stallD=1`; `flushE` during hold clears E.
- Macro off: repeat the load-use case -> `stallF=0` and the dependent instruction enters E on the next edge.
